jpeg_rle: RTL and testbench

- Stage directly downstream of the two-lane reciprocal quantizer in the JPEG accelerator.
- Takes one 8x8 block of quantized coefficients as 32 packed 32-bit words in raster order.
- Buffers the block, re-reads it in JPEG zigzag order and emits run-length symbols (DC, AC run/value, ZRL, EOB) for the Huffman encoder.
- Single-buffered: filling and scanning alternate.

---
 rtl/jpeg_rle.sv | 199 +++++++++++++++++++
 tb/tb_jpeg_rle.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_rle.sv
// jpeg_rle: zigzag run-length coder for one 8x8 block of quantized coefs.
// Ports: clk_i, rst_ni (async, active low), clear_i (sync start-of-image).
//   in_valid_i/in_ready_o/in_data_i : 32 raster words, two coefs each.
//   out_valid_o/out_ready_i : symbol handshake.
//   out_run_o/out_val_o/out_dc_o/out_eob_o : registered symbol fields.
// Optional: `define JPEG_RLE_DC_DPCM_EN sends DC as delta to previous block.
module jpeg_rle #(
  parameter int COEF_W = 16,
  parameter int RUN_W  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2*COEF_W-1:0]   in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [RUN_W-1:0]      out_run_o,
  output logic [COEF_W-1:0]     out_val_o,
  output logic                  out_dc_o,
  output logic                  out_eob_o
);

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_SCAN = 1'b1;

  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] RUN_MAX =
    CNT_W'((1 << RUN_W) - 1);

  logic                state;
  logic [4:0]          wcnt;
  logic [CNT_W-1:0]    idx;
  logic [CNT_W-1:0]    run;
  logic                out_last;
  logic [COEF_W-1:0]   mem [64];
  logic [COEF_W-1:0]   coef;
  logic [COEF_W-1:0]   dc_val;
  logic                acc_in;
  logic                acc_out;
  logic                slot_free;

  function automatic logic [5:0] zz_raster(
    input logic [5:0] z
  );
    logic [5:0] r;
    unique case (z)
      6'd0 : r = 6'd0;   6'd1 : r = 6'd1;
      6'd2 : r = 6'd8;   6'd3 : r = 6'd16;
      6'd4 : r = 6'd9;   6'd5 : r = 6'd2;
      6'd6 : r = 6'd3;   6'd7 : r = 6'd10;
      6'd8 : r = 6'd17;  6'd9 : r = 6'd24;
      6'd10: r = 6'd32;  6'd11: r = 6'd25;
      6'd12: r = 6'd18;  6'd13: r = 6'd11;
      6'd14: r = 6'd4;   6'd15: r = 6'd5;
      6'd16: r = 6'd12;  6'd17: r = 6'd19;
      6'd18: r = 6'd26;  6'd19: r = 6'd33;
      6'd20: r = 6'd40;  6'd21: r = 6'd48;
      6'd22: r = 6'd41;  6'd23: r = 6'd34;
      6'd24: r = 6'd27;  6'd25: r = 6'd20;
      6'd26: r = 6'd13;  6'd27: r = 6'd6;
      6'd28: r = 6'd7;   6'd29: r = 6'd14;
      6'd30: r = 6'd21;  6'd31: r = 6'd28;
      6'd32: r = 6'd35;  6'd33: r = 6'd42;
      6'd34: r = 6'd49;  6'd35: r = 6'd56;
      6'd36: r = 6'd57;  6'd37: r = 6'd50;
      6'd38: r = 6'd43;  6'd39: r = 6'd36;
      6'd40: r = 6'd29;  6'd41: r = 6'd22;
      6'd42: r = 6'd15;  6'd43: r = 6'd23;
      6'd44: r = 6'd30;  6'd45: r = 6'd37;
      6'd46: r = 6'd44;  6'd47: r = 6'd51;
      6'd48: r = 6'd58;  6'd49: r = 6'd59;
      6'd50: r = 6'd52;  6'd51: r = 6'd45;
      6'd52: r = 6'd38;  6'd53: r = 6'd31;
      6'd54: r = 6'd39;  6'd55: r = 6'd46;
      6'd56: r = 6'd53;  6'd57: r = 6'd60;
      6'd58: r = 6'd61;  6'd59: r = 6'd54;
      6'd60: r = 6'd47;  6'd61: r = 6'd55;
      6'd62: r = 6'd62;  6'd63: r = 6'd63;
      default: r = 6'd0;
    endcase
    return r;
  endfunction

  assign in_ready_o = (state == ST_FILL);
  assign acc_in     = in_valid_i & in_ready_o;
  assign acc_out    = out_valid_o & out_ready_i;
  assign slot_free  = ~out_valid_o | out_ready_i;
  assign coef       = mem[zz_raster(idx[5:0])];

  always_ff @(posedge clk_i) begin
    if (acc_in) begin
      mem[{wcnt, 1'b0}] <= in_data_i[2*COEF_W-1:COEF_W];
      mem[{wcnt, 1'b1}] <= in_data_i[COEF_W-1:0];
    end
  end

`ifdef JPEG_RLE_DC_DPCM_EN
  logic [COEF_W-1:0] dc_pred;

  // Predictor follows the DC actually handed downstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dc_pred <= '0;
    end else if (clear_i) begin
      dc_pred <= '0;
    end else if (acc_out && out_dc_o) begin
      dc_pred <= mem[0];
    end
  end

  assign dc_val = mem[0] - dc_pred;
`else
  assign dc_val = mem[0];
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_FILL;
      wcnt        <= '0;
      idx         <= '0;
      run         <= '0;
      out_last    <= 1'b0;
      out_valid_o <= 1'b0;
      out_run_o   <= '0;
      out_val_o   <= '0;
      out_dc_o    <= 1'b0;
      out_eob_o   <= 1'b0;
    end else if (clear_i) begin
      state       <= ST_FILL;
      wcnt        <= '0;
      idx         <= '0;
      run         <= '0;
      out_last    <= 1'b0;
      out_valid_o <= 1'b0;
      out_run_o   <= '0;
      out_val_o   <= '0;
      out_dc_o    <= 1'b0;
      out_eob_o   <= 1'b0;
    end else if (state == ST_FILL) begin
      if (acc_in) begin
        wcnt <= wcnt + 5'd1;
        // Raster 0 landed with word 0, so DC goes out
        // together with the last word.
        if (wcnt == 5'd31) begin
          state       <= ST_SCAN;
          idx         <= CNT_W'(1);
          run         <= '0;
          out_last    <= 1'b0;
          out_valid_o <= 1'b1;
          out_run_o   <= '0;
          out_val_o   <= dc_val;
          out_dc_o    <= 1'b1;
          out_eob_o   <= 1'b0;
        end
      end
    end else if (acc_out && out_last) begin
      state       <= ST_FILL;
      wcnt        <= '0;
      idx         <= '0;
      run         <= '0;
      out_last    <= 1'b0;
      out_valid_o <= 1'b0;
      out_dc_o    <= 1'b0;
      out_eob_o   <= 1'b0;
    end else if (slot_free) begin
      out_valid_o <= 1'b0;
      out_dc_o    <= 1'b0;
      out_eob_o   <= 1'b0;
      out_last    <= 1'b0;
      if (idx[6]) begin
        // Only reached when zz 63 was zero.
        out_valid_o <= 1'b1;
        out_run_o   <= '0;
        out_val_o   <= '0;
        out_eob_o   <= 1'b1;
        out_last    <= 1'b1;
        run         <= '0;
      end else if (coef == '0) begin
        run <= run + CNT_W'(1);
        idx <= idx + CNT_W'(1);
      end else if (run > RUN_MAX) begin
        out_valid_o <= 1'b1;
        out_run_o   <= '1;
        out_val_o   <= '0;
        run         <= run - RUN_MAX - CNT_W'(1);
      end else begin
        out_valid_o <= 1'b1;
        out_run_o   <= run[RUN_W-1:0];
        out_val_o   <= coef;
        out_last    <= (idx == CNT_W'(63));
        run         <= '0;
        idx         <= idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_jpeg_rle.sv
// tb_jpeg_rle: random and directed blocks against a
// zigzag/run-length reference model.
module tb_jpeg_rle;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [3:0]  out_run_o;
  logic [15:0] out_val_o;
  logic        out_dc_o;
  logic        out_eob_o;

  always #5 clk_i = ~clk_i;

  jpeg_rle dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_run_o   (out_run_o),
    .out_val_o   (out_val_o),
    .out_dc_o    (out_dc_o),
    .out_eob_o   (out_eob_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [15:0] blk [64];
  int          zz [64];
  logic [15:0] pred_m = '0;
  logic [21:0] exp_q [$];
  logic [15:0] last_dc = '0;
  int          nsym = 0;

  // zigzag order by walking anti-diagonals
  task automatic make_zz();
    int n;
    int lo;
    int hi;
    int r;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      for (int i = 0; i <= hi - lo; i++) begin
        r = (s % 2 == 0) ? hi - i : lo + i;
        zz[n] = r * 8 + (s - r);
        n++;
      end
    end
  endtask

  task automatic clr_blk();
    for (int i = 0; i < 64; i++) blk[i] = '0;
  endtask

  // symbol = {run, val, dc, eob}
  task automatic build_exp();
    int run;
    logic [15:0] v;
    exp_q.delete();
    run = 0;
    v = blk[0];
`ifdef JPEG_RLE_DC_DPCM_EN
    v = blk[0] - pred_m;
`endif
    exp_q.push_back({4'd0, v, 1'b1, 1'b0});
    for (int z = 1; z < 64; z++) begin
      v = blk[zz[z]];
      if (v == 16'd0) begin
        run++;
      end else begin
        while (run >= 16) begin
          exp_q.push_back({4'd15, 16'd0, 2'b00});
          run -= 16;
        end
        exp_q.push_back({4'(run), v, 2'b00});
        run = 0;
      end
    end
    if (run > 0) exp_q.push_back({4'd0, 16'd0, 2'b01});
  endtask

  task automatic feed();
    out_ready_i = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk_i);
      while ($urandom_range(0, 3) == 0) begin
        in_valid_i = 1'b0;
        @(negedge clk_i);
      end
      chk("in_ready_fill", 32'(in_ready_o), 32'd1);
      in_valid_i = 1'b1;
      in_data_i = {blk[2*k], blk[2*k+1]};
      @(posedge clk_i);
    end
    @(negedge clk_i);
    chk("in_ready_scan", 32'(in_ready_o), 32'd0);
    // left valid with junk: must be ignored while scanning
    in_data_i = $urandom;
  endtask

  task automatic receive(input int mode);
    int cyc;
    logic held;
    logic [21:0] prev;
    logic [21:0] cur;
    cyc = 0;
    held = 1'b0;
    prev = '0;
    nsym = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      cur = {out_run_o, out_val_o, out_dc_o, out_eob_o};
      if (held) begin
        chk("stall_valid", 32'(out_valid_o), 32'd1);
        chk("stall_hold", 32'(cur), 32'(prev));
      end
      case (mode)
        0: out_ready_i = 1'b1;
        1: out_ready_i = ~out_ready_i;
        default: out_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (out_valid_o && out_ready_i) begin
        chk("symbol", 32'(cur), 32'(exp_q.pop_front()));
        nsym++;
        if (out_dc_o) last_dc = out_val_o;
        if (exp_q.size() == 0) in_valid_i = 1'b0;
      end
      held = out_valid_o && !out_ready_i;
      prev = cur;
      @(negedge clk_i);
      cyc++;
    end
    if (exp_q.size() > 0) begin
      chk("timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    chk("done_ready", 32'(in_ready_o), 32'd1);
    chk("done_valid", 32'(out_valid_o), 32'd0);
    out_ready_i = 1'b0;
    in_valid_i = 1'b0;
  endtask

  task automatic run_block(input int mode);
    build_exp();
    feed();
    receive(mode);
    pred_m = blk[0];
  endtask

  task automatic do_clear();
    @(negedge clk_i);
    in_valid_i = 1'b0;
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    pred_m = '0;
    chk("clr_ready", 32'(in_ready_o), 32'd1);
    chk("clr_valid", 32'(out_valid_o), 32'd0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_ready", 32'(in_ready_o), 32'd1);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_run", 32'(out_run_o), 32'd0);
    chk("rst_val", 32'(out_val_o), 32'd0);
    chk("rst_dc", 32'(out_dc_o), 32'd0);
    chk("rst_eob", 32'(out_eob_o), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int dens;
    make_zz();
    #12;
    chk_reset_outs();
    @(negedge clk_i);
    rst_ni = 1'b1;

    clr_blk();
    run_block(0);
    chk("all_zero_nsym", 32'(nsym), 32'd2);

    clr_blk();
    blk[0] = 16'd5;
    blk[1] = 16'hFFFD;
    run_block(0);
    chk("two_coef_nsym", 32'(nsym), 32'd3);

    clr_blk();
    blk[63] = 16'd7;
    run_block(2);
    chk("last_only_nsym", 32'(nsym), 32'd5);

    clr_blk();
    blk[0] = 16'd5;
    blk[1] = 16'hFFFD;
    run_block(1);
    chk("toggle_nsym", 32'(nsym), 32'd3);

    // reset while scanning, right after DC is taken
    clr_blk();
    blk[0] = 16'd3;
    blk[5] = 16'd9;
    build_exp();
    feed();
    out_ready_i = 1'b1;
    cyc = 0;
    while (!out_valid_o && cyc < 100) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("mid_dc_seen", 32'(out_valid_o), 32'd1);
    @(posedge clk_i);
    #2;
    in_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk_reset_outs();
    @(negedge clk_i);
    rst_ni = 1'b1;
    out_ready_i = 1'b0;
    pred_m = '0;
    exp_q.delete();
    run_block(0);

    // DC prediction across blocks and after clear
    do_clear();
    clr_blk();
    blk[0] = 16'd10;
    blk[9] = 16'd2;
    run_block(0);
    chk("dc_blk1", 32'(last_dc), 32'd10);
    blk[0] = 16'd4;
    run_block(2);
`ifdef JPEG_RLE_DC_DPCM_EN
    chk("dc_blk2", 32'(last_dc), 32'h0000FFFA);
`else
    chk("dc_blk2", 32'(last_dc), 32'd4);
`endif
    do_clear();
    run_block(1);
    chk("dc_blk3", 32'(last_dc), 32'd4);

    // clear while a block is scanning
    clr_blk();
    blk[0] = 16'd1;
    build_exp();
    feed();
    exp_q.delete();
    do_clear();
    clr_blk();
    blk[0] = 16'd8;
    blk[40] = 16'hFF00;
    run_block(2);

    for (int b = 0; b < 25; b++) begin
      case ($urandom_range(0, 3))
        0: dens = 2;
        1: dens = 10;
        2: dens = 40;
        default: dens = 90;
      endcase
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(0, 99) < dens)
          blk[i] = 16'($urandom);
        else
          blk[i] = '0;
      end
      run_block(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
